// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction-fetch unit.
// Owns the fetch PC, issues one I-Cache read at a time, buffers returned
// instructions in a DEPTH-entry FIFO and hands the head to IF/ID through a
// valid/ready handshake. A redirect flushes the queue and, if a request is
// still outstanding, discards its response before fetching at the target.
// Optional feature macro: IF_MISS_CNT_EN (adds miss_cnt_o, a saturating
// count of responses returned with icache_hit=0).
module if_fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                IDX_W    = 12,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [IDX_W-1:0]  icache_req_addr,
    output logic              icache_req_valid,
    output logic              icache_req_rw,
    input  logic [31:0]       icache_data_read,
    input  logic              icache_ready,
    input  logic              icache_hit,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [31:0]       inst_o,
    input  logic              inst_ready_i,
    output logic              hold_flag_if_o
`ifdef IF_MISS_CNT_EN
    ,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [IDX_W-1:0]   drop_addr_q, drop_addr_d;
    logic               req_valid_q, req_valid_d;
    logic [IDX_W-1:0]   req_addr_q, req_addr_d;

    logic [ADDR_W-1:0]  addr_mem_q [DEPTH];
    logic [31:0]        inst_mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic               not_empty;

    assign not_empty = (count_q != '0);

    // Next-state: redirect first, then per-state push/pop bookkeeping.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (redirect_valid_i) begin
            // Flush; the head is not consumed and any response is dropped.
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            pc_d    = redirect_addr_i & ~ADDR_W'(3);
            case (state_q)
                S_FETCH: begin
                    if (icache_ready) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q[IDX_W+1:2];
                    end
                end
                S_FULL:  state_d = S_FETCH;
                // A stale response landing with the new redirect still
                // completes the drop, otherwise we would wait forever.
                S_DROP:  state_d = icache_ready ? S_FETCH : S_DROP;
                default: state_d = S_FETCH;
            endcase
        end else begin
            pop = not_empty & inst_ready_i;
            case (state_q)
                S_FETCH: push = icache_ready;
                S_FULL:  if (pop) state_d = S_FETCH;
                S_DROP:  if (icache_ready) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
                pc_d   = pc_q + ADDR_W'(4);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (state_q == S_FETCH && count_d == FULL_CNT) begin
                state_d = S_FULL;
            end
        end

        // Request outputs are registered from the next-state values.
        req_valid_d = (state_d != S_FULL);
        req_addr_d  = (state_d == S_DROP) ? drop_addr_d : pc_d[IDX_W+1:2];
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            drop_addr_q <= '0;
            req_valid_q <= 1'b1;
            req_addr_q  <= RESET_PC[IDX_W+1:2];
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            drop_addr_q <= drop_addr_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_mem_q[tail_q] <= pc_q;
            inst_mem_q[tail_q] <= icache_data_read;
        end
    end

    assign icache_req_valid = req_valid_q;
    assign icache_req_addr  = req_addr_q;
    assign icache_req_rw    = 1'b0;

    assign inst_valid_o   = not_empty;
    assign inst_addr_o    = not_empty ? addr_mem_q[head_q] : '0;
    assign inst_o         = not_empty ? inst_mem_q[head_q] : NOP_INST;
    assign hold_flag_if_o = ~not_empty & ~rst;

`ifdef IF_MISS_CNT_EN
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Count miss responses seen while a request is outstanding; saturating.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (state_q != S_FULL && icache_ready && !icache_hit && miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Miss counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt_o = miss_cnt_q;
`else
    // Hit status only feeds the miss counter.
    logic unused_hit;
    assign unused_hit = icache_hit;
`endif

endmodule
